// File: rtl/pcie_rx_pkg.sv
// rtl/pcie_rx_pkg.sv - shared constants, block classes and LFSR helper for the gen3 RX descrambler
package pcie_rx_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

  localparam logic [7:0] OS_SKP   = 8'hAA;
  localparam logic [7:0] OS_EIEOS = 8'h00;
  localparam logic [7:0] OS_TS1   = 8'h1E;
  localparam logic [7:0] OS_TS2   = 8'h2D;
  localparam logic [7:0] OS_SDS   = 8'hE1;

  localparam int BLK_SYMS = 16;

  // G(X) = X^23 + X^21 + X^16 + X^8 + X^5 + X^2 + 1, X^23 term implied by the shift-out
  localparam int LFSR_W = 23;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h210125;

  typedef enum logic [1:0] {
    BLK_DATA,
    BLK_SKP,
    BLK_EIEOS,
    BLK_OS
  } blk_class_e;

  typedef struct packed {
    logic [7:0]        ks;
    logic [LFSR_W-1:0] next;
  } lfsr_step_t;

  // Eight Galois shifts: keystream bit i is the MSB before shift i, so byte bit 0 goes first on the wire
  function automatic lfsr_step_t lfsr_step8(input logic [LFSR_W-1:0] state);
    lfsr_step_t        r;
    logic [LFSR_W-1:0] s;
    s    = state;
    r.ks = '0;
    for (int i = 0; i < 8; i++) begin
      r.ks[i] = s[LFSR_W-1];
      s = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_POLY : '0);
    end
    r.next = s;
    return r;
  endfunction

  // Invalid headers fall back to data-block handling
  function automatic blk_class_e classify(input logic [1:0] hdr, input logic [7:0] sym0);
    blk_class_e c;
    c = BLK_DATA;
    if (hdr == SYNC_OS) begin
      case (sym0)
        OS_SKP:                 c = BLK_SKP;
        OS_EIEOS:               c = BLK_EIEOS;
        OS_TS1, OS_TS2, OS_SDS: c = BLK_OS;
        default:                c = BLK_OS;
      endcase
    end
    return c;
  endfunction

  function automatic logic sync_hdr_ok(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
  endfunction

endpackage

// File: rtl/descrambler_lane.sv
// rtl/descrambler_lane.sv - one lane: LFSR, symbol counter, block class, per-byte XOR and lane flags
module descrambler_lane
  import pcie_rx_pkg::*;
#(
  parameter int LANE_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bypass,
  input  logic                    seed_load,
  input  logic [LFSR_W-1:0]       seed,
  input  logic                    in_valid,
  input  logic                    in_start_block,
  input  logic [1:0]              sync_hdr,
  input  logic [LANE_BYTES*8-1:0] data_in,
  output logic [LANE_BYTES*8-1:0] data_out,
  output logic                    skp,
  output logic                    sync_err,
  output logic [3:0]              sym_cnt
);

  localparam logic [3:0] BEAT_STEP = 4'(LANE_BYTES % BLK_SYMS);
  localparam logic [3:0] LAST_SYM  = 4'(BLK_SYMS - 1);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [3:0]        cnt_q, cnt_d;
  blk_class_e        cls_q, cls_d;

  logic [LFSR_W-1:0] state;
  logic [3:0]        base;
  logic [3:0]        sym;
  blk_class_e        beat_cls;
  lfsr_step_t        step;

  // Unrolled per-symbol descramble; seed_load is applied before the beat, class decode before any XOR
  always_comb begin
    state    = seed_load ? seed : lfsr_q;
    base     = (seed_load || in_start_block) ? 4'd0 : cnt_q;
    beat_cls = in_start_block ? classify(sync_hdr, data_in[7:0]) : cls_q;
    lfsr_d   = state;
    cnt_d    = seed_load ? 4'd0 : cnt_q;
    cls_d    = cls_q;
    data_out = data_in;
    skp      = 1'b0;
    sync_err = 1'b0;
    sym      = 4'd0;
    step     = '0;
    if (in_valid) begin
      cnt_d    = base + BEAT_STEP;
      cls_d    = beat_cls;
      skp      = (beat_cls == BLK_SKP);
      sync_err = in_start_block && !sync_hdr_ok(sync_hdr);
      if (!bypass) begin
        for (int k = 0; k < LANE_BYTES; k++) begin
          sym  = base + 4'(k);
          step = lfsr_step8(state);
          case (beat_cls)
            BLK_DATA: begin
              data_out[k*8 +: 8] = data_out[k*8 +: 8] ^ step.ks;
              state = step.next;
            end
            BLK_SKP: begin
            end
            BLK_EIEOS: begin
              if (sym == LAST_SYM) state = seed;
            end
            default: begin
              if (sym != 4'd0) data_out[k*8 +: 8] = data_out[k*8 +: 8] ^ step.ks;
              state = step.next;
            end
          endcase
        end
        lfsr_d = state;
      end
    end
  end

  // Lane state registers; after reset the lane behaves as if inside a data block
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= seed;
      cnt_q  <= 4'd0;
      cls_q  <= BLK_DATA;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      cls_q  <= cls_d;
    end
  end

  assign sym_cnt = cnt_q;

endmodule

// File: rtl/multilane_gen3_descrambler.sv
// rtl/multilane_gen3_descrambler.sv - NUM_LANES 128b/130b descrambler with registered outputs and error flags
module multilane_gen3_descrambler
  import pcie_rx_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_BYTES = 4,
  parameter int SEED_W     = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              bypass,
  input  logic                              seed_load,
  input  logic [NUM_LANES*SEED_W-1:0]       lane_seed,
  input  logic                              in_valid,
  input  logic                              in_start_block,
  input  logic [2*NUM_LANES-1:0]            in_sync_hdr,
  input  logic [NUM_LANES*LANE_BYTES*8-1:0] in_data,
  output logic                              out_valid,
  output logic                              out_start_block,
  output logic [2*NUM_LANES-1:0]            out_sync_hdr,
  output logic [NUM_LANES*LANE_BYTES*8-1:0] out_data,
  output logic [NUM_LANES-1:0]              out_skp,
  output logic [NUM_LANES-1:0]              sync_err,
  output logic                              align_err
);

  localparam int LANE_W = LANE_BYTES * 8;
  localparam int DATA_W = NUM_LANES * LANE_W;

  logic [DATA_W-1:0]    data_c;
  logic [NUM_LANES-1:0] skp_c;
  logic [NUM_LANES-1:0] sync_err_c;
  logic [NUM_LANES-1:0] cnt_nz;

  // Seed bits above the LFSR width carry no meaning
  logic unused_seed;
  assign unused_seed = ^lane_seed;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic [3:0] sym_cnt;

    descrambler_lane #(
      .LANE_BYTES(LANE_BYTES)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .bypass        (bypass),
      .seed_load     (seed_load),
      .seed          (lane_seed[n*SEED_W +: LFSR_W]),
      .in_valid      (in_valid),
      .in_start_block(in_start_block),
      .sync_hdr      (in_sync_hdr[n*2 +: 2]),
      .data_in       (in_data[n*LANE_W +: LANE_W]),
      .data_out      (data_c[n*LANE_W +: LANE_W]),
      .skp           (skp_c[n]),
      .sync_err      (sync_err_c[n]),
      .sym_cnt       (sym_cnt)
    );

    assign cnt_nz[n] = |sym_cnt;
  end

  logic                 out_valid_q, out_valid_d;
  logic                 out_start_block_q, out_start_block_d;
  logic [2*NUM_LANES-1:0] out_sync_hdr_q, out_sync_hdr_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [NUM_LANES-1:0] out_skp_q, out_skp_d;
  logic [NUM_LANES-1:0] sync_err_q, sync_err_d;
  logic                 align_err_q, align_err_d;

  // Next output values; a block start is misaligned when the lanes are not at symbol 0
  always_comb begin
    out_valid_d       = in_valid;
    out_start_block_d = in_start_block;
    out_sync_hdr_d    = in_sync_hdr;
    out_data_d        = data_c;
    out_skp_d         = skp_c;
    sync_err_d        = sync_err_c;
    align_err_d       = in_valid && in_start_block && !seed_load && (|cnt_nz);
  end

  // One-cycle output stage, cleared on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q       <= 1'b0;
      out_start_block_q <= 1'b0;
      out_sync_hdr_q    <= '0;
      out_data_q        <= '0;
      out_skp_q         <= '0;
      sync_err_q        <= '0;
      align_err_q       <= 1'b0;
    end else begin
      out_valid_q       <= out_valid_d;
      out_start_block_q <= out_start_block_d;
      out_sync_hdr_q    <= out_sync_hdr_d;
      out_data_q        <= out_data_d;
      out_skp_q         <= out_skp_d;
      sync_err_q        <= sync_err_d;
      align_err_q       <= align_err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_start_block = out_start_block_q;
  assign out_sync_hdr    = out_sync_hdr_q;
  assign out_data        = out_data_q;
  assign out_skp         = out_skp_q;
  assign sync_err        = sync_err_q;
  assign align_err       = align_err_q;

endmodule

// File: tb/tb_multilane_gen3_descrambler.sv
// tb/tb_multilane_gen3_descrambler.sv - table-driven and randomized checks against a block-level model
module tb_multilane_gen3_descrambler;

  localparam int NL = 4;
  localparam int LB = 4;
  localparam int SW = 24;
  localparam int DW = NL * LB * 8;

  // G(X) = X^23 + X^21 + X^16 + X^8 + X^5 + X^2 + 1
  localparam int unsigned POLY_M = (1 << 21) | (1 << 16) | (1 << 8) | (1 << 5) | (1 << 2) | 1;

  localparam int K_ZERO  = 0;
  localparam int K_RAND  = 1;
  localparam int K_SKP   = 2;
  localparam int K_EIE   = 3;
  localparam int K_OS    = 4;
  localparam int K_BAD11 = 5;
  localparam int K_BAD00 = 6;
  localparam int K_BEEF  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, bypass, seed_load, in_valid, in_start_block;
  logic [NL*SW-1:0] lane_seed;
  logic [2*NL-1:0]  in_sync_hdr, out_sync_hdr;
  logic [DW-1:0]    in_data, out_data;
  logic             out_valid, out_start_block, align_err;
  logic [NL-1:0]    out_skp, sync_err;

  multilane_gen3_descrambler #(.NUM_LANES(NL), .LANE_BYTES(LB), .SEED_W(SW)) dut (
    .clk(clk), .reset(reset), .bypass(bypass), .seed_load(seed_load), .lane_seed(lane_seed),
    .in_valid(in_valid), .in_start_block(in_start_block), .in_sync_hdr(in_sync_hdr), .in_data(in_data),
    .out_valid(out_valid), .out_start_block(out_start_block), .out_sync_hdr(out_sync_hdr),
    .out_data(out_data), .out_skp(out_skp), .sync_err(sync_err), .align_err(align_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-lane scrambler state as a plain integer, stepped one keystream byte at a time
  int unsigned m_lfsr[NL];
  int unsigned m_seed[NL];
  logic [7:0]  blk[NL][16];

  task automatic ks_next(input int n, output logic [7:0] b);
    int unsigned top;
    for (int i = 0; i < 8; i++) begin
      top = (m_lfsr[n] >> 22) & 1;
      b[i] = top[0];
      m_lfsr[n] = ((m_lfsr[n] << 1) & 32'h7FFFFF) ^ (top != 0 ? POLY_M : 0);
    end
  endtask

  task automatic fill_lane(input int n, input int kind, input logic [7:0] code, output logic [1:0] h);
    logic [31:0] beef;
    beef = 32'hDEADBEEF;
    h = 2'b01;
    for (int i = 0; i < 16; i++) blk[n][i] = 8'($urandom);
    case (kind)
      K_ZERO:  for (int i = 0; i < 16; i++) blk[n][i] = 8'h00;
      K_SKP:   begin h = 2'b10; for (int i = 0; i < 16; i++) blk[n][i] = 8'hAA; end
      K_EIE:   begin h = 2'b10; blk[n][0] = 8'h00; end
      K_OS:    begin h = 2'b10; blk[n][0] = code; end
      K_BAD11: h = 2'b11;
      K_BAD00: h = 2'b00;
      K_BEEF:  for (int i = 0; i < 16; i++) blk[n][i] = 8'(beef >> (8 * (i % 4)));
      default: ;
    endcase
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, " out_start_block"}, 128'(out_start_block), 128'(0));
    chk({tag, " out_sync_hdr"}, 128'(out_sync_hdr), 128'(0));
    chk({tag, " out_data"}, 128'(out_data), 128'(0));
    chk({tag, " out_skp"}, 128'(out_skp), 128'(0));
    chk({tag, " sync_err"}, 128'(sync_err), 128'(0));
    chk({tag, " align_err"}, 128'(align_err), 128'(0));
  endtask

  // Sends nbeats of the block held in blk[][]; expected bytes come from the block-level rules
  task automatic send_block(input int nbeats, input logic [2*NL-1:0] hdrs, input bit byp, input bit sl,
                            input logic [NL*SW-1:0] new_seed, input bit gap, input bit exp_align,
                            input logic [NL-1:0] eskp, input logic [NL-1:0] eserr, input string tag);
    logic [7:0]    expb[NL][16];
    logic [7:0]    k;
    logic [7:0]    b0;
    logic [DW-1:0] ed;
    logic [DW-1:0] raw;
    bit            is_os, is_skp, is_eie;
    if (sl) begin
      for (int n = 0; n < NL; n++) begin
        m_seed[n] = {9'd0, new_seed[n*SW +: 23]};
        m_lfsr[n] = m_seed[n];
      end
    end
    for (int n = 0; n < NL; n++) begin
      b0     = blk[n][0];
      is_skp = (hdrs[n*2 +: 2] == 2'b10) && (b0 == 8'hAA);
      is_eie = (hdrs[n*2 +: 2] == 2'b10) && (b0 == 8'h00);
      is_os  = (hdrs[n*2 +: 2] == 2'b10) && !is_skp && !is_eie;
      for (int i = 0; i < nbeats * LB; i++) begin
        if (byp || is_skp || is_eie) begin
          expb[n][i] = blk[n][i];
        end else if (is_os) begin
          ks_next(n, k);
          expb[n][i] = (i == 0) ? blk[n][i] : (blk[n][i] ^ k);
        end else begin
          ks_next(n, k);
          expb[n][i] = blk[n][i] ^ k;
        end
      end
      if (!byp && is_eie && nbeats == 4) m_lfsr[n] = m_seed[n];
    end
    for (int b = 0; b < nbeats; b++) begin
      if (gap && b == 1) begin
        in_valid = 1'b0;
        in_start_block = 1'b0;
        for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom;
        raw = in_data;
        @(posedge clk); #1;
        chk($sformatf("%s idle out_valid", tag), 128'(out_valid), 128'(0));
        chk($sformatf("%s idle out_data", tag), 128'(out_data), 128'(raw));
        chk($sformatf("%s idle out_skp", tag), 128'(out_skp), 128'(0));
      end
      bypass = byp;
      seed_load = sl && (b == 0);
      if (sl && b == 0) lane_seed = new_seed;
      in_valid = 1'b1;
      in_start_block = (b == 0);
      in_sync_hdr = hdrs;
      for (int n = 0; n < NL; n++)
        for (int kk = 0; kk < LB; kk++) begin
          in_data[(n*LB+kk)*8 +: 8] = blk[n][b*LB+kk];
          ed[(n*LB+kk)*8 +: 8] = expb[n][b*LB+kk];
        end
      @(posedge clk); #1;
      seed_load = 1'b0;
      chk($sformatf("%s b%0d out_valid", tag, b), 128'(out_valid), 128'(1));
      chk($sformatf("%s b%0d out_start_block", tag, b), 128'(out_start_block), 128'(b == 0));
      chk($sformatf("%s b%0d out_sync_hdr", tag, b), 128'(out_sync_hdr), 128'(hdrs));
      chk($sformatf("%s b%0d out_data", tag, b), 128'(out_data), 128'(ed));
      chk($sformatf("%s b%0d out_skp", tag, b), 128'(out_skp), 128'(eskp));
      chk($sformatf("%s b%0d sync_err", tag, b), 128'(sync_err), 128'((b == 0) ? eserr : '0));
      chk($sformatf("%s b%0d align_err", tag, b), 128'(align_err), 128'((b == 0) && exp_align));
    end
    in_valid = 1'b0;
    in_start_block = 1'b0;
    bypass = 1'b0;
  endtask

  typedef struct {
    int            kind_all;
    int            kind_l2;
    logic [7:0]    code;
    bit            byp;
    logic [NL-1:0] exp_skp;
    logic [NL-1:0] exp_serr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [2*NL-1:0]  hdrs;
    logic [1:0]       h;
    logic [NL*SW-1:0] ns;
    logic [7:0]       codes[4];
    int               kinds[NL];
    logic [NL-1:0]    eskp, eserr;
    bit               byp, sl, gap;

    tbl[0]  = '{K_ZERO, K_ZERO,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{K_RAND, K_RAND,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{K_SKP,  K_SKP,   8'h00, 1'b0, 4'b1111, 4'b0000};
    tbl[3]  = '{K_RAND, K_RAND,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[4]  = '{K_OS,   K_OS,    8'h1E, 1'b0, 4'b0000, 4'b0000};
    tbl[5]  = '{K_RAND, K_RAND,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[6]  = '{K_EIE,  K_EIE,   8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[7]  = '{K_ZERO, K_ZERO,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[8]  = '{K_RAND, K_BAD11, 8'h00, 1'b0, 4'b0000, 4'b0100};
    tbl[9]  = '{K_OS,   K_OS,    8'hE1, 1'b0, 4'b0000, 4'b0000};
    tbl[10] = '{K_OS,   K_OS,    8'h2D, 1'b0, 4'b0000, 4'b0000};
    tbl[11] = '{K_EIE,  K_EIE,   8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[12] = '{K_BEEF, K_BEEF,  8'h00, 1'b1, 4'b0000, 4'b0000};
    tbl[13] = '{K_ZERO, K_ZERO,  8'h00, 1'b0, 4'b0000, 4'b0000};
    tbl[14] = '{K_OS,   K_SKP,   8'h55, 1'b0, 4'b0100, 4'b0000};
    codes[0] = 8'h1E; codes[1] = 8'h2D; codes[2] = 8'hE1; codes[3] = 8'h55;

    reset = 1'b0;
    bypass = 1'b0;
    seed_load = 1'b0;
    in_valid = 1'b1;
    in_start_block = 1'b1;
    in_sync_hdr = 8'h5A;
    for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom;
    for (int n = 0; n < NL; n++) lane_seed[n*SW +: SW] = 24'($urandom);
    lane_seed[23:0] = 24'h9DBFBC;
    for (int n = 0; n < NL; n++) begin
      m_seed[n] = {9'd0, lane_seed[n*SW +: 23]};
      m_lfsr[n] = m_seed[n];
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    in_valid = 1'b0;
    in_start_block = 1'b0;

    for (int t = 0; t < 15; t++) begin
      for (int n = 0; n < NL; n++) begin
        fill_lane(n, (n == 2) ? tbl[t].kind_l2 : tbl[t].kind_all, tbl[t].code, h);
        hdrs[n*2 +: 2] = h;
      end
      send_block(4, hdrs, tbl[t].byp, 1'b0, lane_seed, 1'b0, 1'b0, tbl[t].exp_skp, tbl[t].exp_serr,
                 $sformatf("vec%0d", t));
    end

    for (int n = 0; n < NL; n++) begin fill_lane(n, K_RAND, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(2, hdrs, 1'b0, 1'b0, lane_seed, 1'b0, 1'b0, '0, '0, "align_pre");
    for (int n = 0; n < NL; n++) begin fill_lane(n, K_RAND, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(4, hdrs, 1'b0, 1'b0, lane_seed, 1'b0, 1'b1, '0, '0, "align_new");

    for (int n = 0; n < NL; n++) ns[n*SW +: SW] = 24'($urandom);
    for (int n = 0; n < NL; n++) begin fill_lane(n, K_ZERO, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(4, hdrs, 1'b0, 1'b1, ns, 1'b0, 1'b0, '0, '0, "seed_load");

    for (int n = 0; n < NL; n++) begin fill_lane(n, K_RAND, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(2, hdrs, 1'b0, 1'b0, lane_seed, 1'b0, 1'b0, '0, '0, "rst_pre");
    reset = 1'b0;
    in_valid = 1'b1;
    for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    reset = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < NL; n++) m_lfsr[n] = m_seed[n];
    for (int n = 0; n < NL; n++) begin fill_lane(n, K_ZERO, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(4, hdrs, 1'b0, 1'b0, lane_seed, 1'b0, 1'b0, '0, '0, "rst_post");

    for (int n = 0; n < NL; n++) begin fill_lane(n, K_RAND, 8'h00, h); hdrs[n*2 +: 2] = h; end
    send_block(4, hdrs, 1'b0, 1'b0, lane_seed, 1'b1, 1'b0, '0, '0, "gap");

    for (int r = 0; r < 60; r++) begin
      eskp = '0;
      eserr = '0;
      for (int n = 0; n < NL; n++) begin
        kinds[n] = $urandom_range(0, 6);
        fill_lane(n, kinds[n], codes[$urandom_range(0, 3)], h);
        hdrs[n*2 +: 2] = h;
        eskp[n] = (kinds[n] == K_SKP);
        eserr[n] = (kinds[n] == K_BAD11) || (kinds[n] == K_BAD00);
      end
      byp = ($urandom_range(0, 7) == 0);
      sl  = ($urandom_range(0, 7) == 0);
      gap = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < NL; n++) ns[n*SW +: SW] = 24'($urandom);
      send_block(4, hdrs, byp, sl, sl ? ns : lane_seed, gap, 1'b0, eskp, eserr, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
